refund_dispenser: RTL and testbench

Converts a refund balance in cents into a sequence of coin-eject commands for the coin hopper. Sits directly downstream of the vending controller: it receives the refund balance when the controller enters its refund state and drives the hopper with greedy coin selection and a 4-phase handshake. Runs on the undivided system clock and has no internal clock divider.

---
 rtl/refund_dispenser_if.sv | 26 ++
 rtl/refund_dispenser.sv | 133 +++++++++++++
 tb/tb_refund_dispenser.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/refund_dispenser_if.sv
// Vending-controller and hopper signals of the refund dispenser.
// The master side is the environment; the slave side is the dispenser.
interface refund_dispenser_if;
  logic        start;
  logic [31:0] amount;
  logic        hopperAck;
  logic        empty10;
  logic        empty1;
  logic        eject10;
  logic        eject1;
  logic        eject050;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] remaining;

  modport master (
    output start, amount, hopperAck, empty10, empty1,
    input  eject10, eject1, eject050, busy, done, fault, remaining
  );

  modport slave (
    input  start, amount, hopperAck, empty10, empty1,
    output eject10, eject1, eject050, busy, done, fault, remaining
  );
endinterface

// File: rtl/refund_dispenser.sv
// Greedy coin refund: start -> SELECT next cycle, eject the cycle after, 4-phase hopper handshake per coin.
// The hopper paces the refund by holding or releasing hopperAck; a stalled handshake edge faults after TIMEOUT cycles.
module refund_dispenser #(
  parameter int TIMEOUT   = 1000,
  parameter int MAX_CENTS = 99999
) (
  input logic               clk,
  input logic               rst,
  refund_dispenser_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJECT, S_RELEASE, S_DONE, S_FAULT
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_eject10;
  logic          r_eject1;
  logic          r_eject050;
  logic          r_busy;
  logic          r_done;
  logic          r_fault;
  logic [31:0]   r_remaining;

  logic [31:0]   w_coin_val;
  logic          w_timeout;

  // The active eject line identifies the coin being paid.
  always_comb begin
    w_coin_val = 32'd50;
    if (r_eject10)     w_coin_val = 32'd1000;
    else if (r_eject1) w_coin_val = 32'd100;
  end

  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_eject10   <= 1'b0;
      r_eject1    <= 1'b0;
      r_eject050  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.amount > 32'(MAX_CENTS)) begin
              r_fault <= 1'b1;
              r_state <= S_FAULT;
            end else begin
              r_remaining <= bus.amount;
              r_busy      <= 1'b1;
              r_state     <= S_SELECT;
            end
          end
        end

        S_SELECT: begin
          r_timer <= '0;
          if (r_remaining >= 32'd1000 && !bus.empty10) begin
            r_eject10 <= 1'b1;
            r_state   <= S_EJECT;
          end else if (r_remaining >= 32'd100 && !bus.empty1) begin
            r_eject1 <= 1'b1;
            r_state  <= S_EJECT;
          end else if (r_remaining >= 32'd50) begin
            r_eject050 <= 1'b1;
            r_state    <= S_EJECT;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_EJECT: begin
          if (bus.hopperAck) begin
            r_eject10   <= 1'b0;
            r_eject1    <= 1'b0;
            r_eject050  <= 1'b0;
            r_remaining <= r_remaining - w_coin_val;
            r_timer     <= '0;
            r_state     <= S_RELEASE;
          end else if (w_timeout) begin
            r_eject10  <= 1'b0;
            r_eject1   <= 1'b0;
            r_eject050 <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= S_FAULT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_RELEASE: begin
          if (!bus.hopperAck) begin
            r_state <= S_SELECT;
          end else if (w_timeout) begin
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_DONE:  r_state <= S_IDLE;

        // Sticky until reset; remaining stays frozen for diagnosis.
        S_FAULT: r_state <= S_FAULT;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.eject10   = r_eject10;
  assign bus.eject1    = r_eject1;
  assign bus.eject050  = r_eject050;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.fault     = r_fault;
  assign bus.remaining = r_remaining;
endmodule

// File: tb/tb_refund_dispenser.sv
// Directed bench for refund_dispenser: greedy-plan model checked every cycle plus literal timing checks.
module tb_refund_dispenser;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  refund_dispenser_if bus();
  refund_dispenser #(.TIMEOUT(8), .MAX_CENTS(99999)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  // hopper model: 0 = normal 4-phase, 1 = never acks, 2 = acks once and sticks high
  int hop_mode  = 0;
  int ack_delay = 2;
  int hop_cnt   = 0;

  int          q[$];
  int          seen[$];
  int unsigned m_rem;
  int unsigned m_residue;
  bit          chk_en = 1'b0;
  logic [2:0]  prev_ej = 3'b000;

  logic eject_any;
  assign eject_any = bus.eject10 | bus.eject1 | bus.eject050;

  initial begin
    bus.hopperAck = 1'b0;
    forever begin
      @(negedge clk);
      if (!eject_any) hop_cnt = 0;
      if (hop_mode == 1) begin
        bus.hopperAck = 1'b0;
      end else if (eject_any && !bus.hopperAck) begin
        if (hop_cnt >= ack_delay) begin
          bus.hopperAck = 1'b1;
          hop_cnt = 0;
        end else begin
          hop_cnt++;
        end
      end else if (!eject_any && bus.hopperAck && hop_mode == 0) begin
        bus.hopperAck = 1'b0;
      end
    end
  end

  function automatic int cval(input logic [2:0] ej);
    case (ej)
      3'b100:  return 1000;
      3'b010:  return 100;
      3'b001:  return 50;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Greedy payout plan computed straight from the coin rules.
  task automatic plan(input int a, input bit e10, input bit e1);
    int r;
    r = a;
    q.delete();
    seen.delete();
    m_rem = a;
    while (r >= 50) begin
      if (r >= 1000 && !e10)   begin q.push_back(1000); r -= 1000; end
      else if (r >= 100 && !e1) begin q.push_back(100); r -= 100; end
      else                     begin q.push_back(50); r -= 50; end
    end
    m_residue = r;
  endtask

  task automatic tick();
    logic [2:0] ej;
    int exp_coin;
    @(negedge clk);
    ej = {bus.eject10, bus.eject1, bus.eject050};
    if (chk_en) begin
      if (ej != 3'b000) check("eject_onehot", $countones(ej), 1);
      if (ej != 3'b000 && prev_ej == 3'b000) begin
        exp_coin = (q.size() > 0) ? q[0] : 0;
        seen.push_back(cval(ej));
        check("coin_select", cval(ej), exp_coin);
      end
      if (ej == 3'b000 && prev_ej != 3'b000) begin
        if (q.size() > 0) void'(q.pop_front());
        m_rem = m_rem - cval(prev_ej);
        check("rem_after_coin", bus.remaining, m_rem);
      end
      if (bus.done) begin
        check("done_residue", bus.remaining, m_residue);
        check("done_all_paid", q.size(), 0);
        check("done_busy_low", bus.busy, 0);
      end
    end
    prev_ej = ej;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.amount = '0;
    bus.empty10 = 1'b0;
    bus.empty1 = 1'b0;
    hop_mode = 1;
    chk_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    hop_mode = 0;
    tick();
  endtask

  task automatic pulse_start(input logic [31:0] a);
    bus.start = 1'b1;
    bus.amount = a;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.done && !bus.fault && n < budget) begin
      tick();
      n++;
    end
    check(name, bus.done, 1);
  endtask

  task automatic wait_eject(input string name, input logic want, input int budget);
    int n;
    n = 0;
    while (eject_any != want && n < budget) begin
      tick();
      n++;
    end
    check(name, eject_any, want);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.amount = '0;
    bus.empty10 = 1'b0;
    bus.empty1 = 1'b0;
    tick();
    check("reset_outputs", {bus.eject10, bus.eject1, bus.eject050, bus.busy, bus.done, bus.fault}, 0);
    check("reset_remaining", bus.remaining, 0);
    do_reset();

    // 1250 cents: 10, 1, 1, 0.5 CNY
    plan(1250, 1'b0, 1'b0);
    chk_en = 1'b1;
    pulse_start(1250);
    check("t1_busy", bus.busy, 1);
    check("t1_remaining", bus.remaining, 1250);
    tick();
    check("t2_eject10", bus.eject10, 1);
    wait_done("done_1250", 200);
    check("rem_1250", bus.remaining, 0);
    check("coins_1250", seen.size(), 4);
    if (seen.size() == 4) begin
      check("coin0_1250", seen[0], 1000);
      check("coin1_1250", seen[1], 100);
      check("coin2_1250", seen[2], 100);
      check("coin3_1250", seen[3], 50);
    end
    tick();
    check("done_pulse_1cyc", bus.done, 0);
    check("idle_busy_low", bus.busy, 0);

    // 1000 cents with the 10 CNY tube empty
    bus.empty10 = 1'b1;
    plan(1000, 1'b1, 1'b0);
    pulse_start(1000);
    wait_done("done_1000_e10", 400);
    check("rem_1000_e10", bus.remaining, 0);
    check("coins_1000_e10", seen.size(), 10);
    check("sum_1000_e10", seen.sum(), 1000);
    bus.empty10 = 1'b0;
    tick();

    // 120 cents: one 1 CNY coin, residue 20
    plan(120, 1'b0, 1'b0);
    pulse_start(120);
    wait_done("done_120", 100);
    check("rem_120", bus.remaining, 20);
    check("coins_120", seen.size(), 1);
    tick();

    // 30 cents: done at t+2 without any eject
    plan(30, 1'b0, 1'b0);
    pulse_start(30);
    check("t1_busy_30", bus.busy, 1);
    check("t1_rem_30", bus.remaining, 30);
    tick();
    check("t2_done_30", bus.done, 1);
    check("t2_noeject_30", eject_any, 0);
    check("t2_rem_30", bus.remaining, 30);
    tick();
    check("t3_done_low_30", bus.done, 0);

    // over-limit amount faults; later starts ignored
    chk_en = 1'b0;
    pulse_start(100000);
    check("over_fault", bus.fault, 1);
    check("over_busy", bus.busy, 0);
    check("over_noeject", eject_any, 0);
    tick();
    pulse_start(100);
    tick();
    check("fault_sticky", bus.fault, 1);
    check("fault_ignores_start", {eject_any, bus.busy}, 0);
    do_reset();
    check("rst_clears_fault", bus.fault, 0);

    // ack never arrives: fault 8 cycles after EJECT entry
    hop_mode = 1;
    pulse_start(100);
    tick();
    check("toA_eject1", bus.eject1, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("toA_hold", {bus.fault, bus.eject1}, 2'b01);
    end
    tick();
    check("toA_fault", bus.fault, 1);
    check("toA_eject_drop", eject_any, 0);
    check("toA_busy", bus.busy, 0);
    check("toA_rem_frozen", bus.remaining, 100);
    do_reset();

    // ack stuck high in RELEASE: fault 8 cycles after RELEASE entry
    hop_mode = 2;
    pulse_start(100);
    wait_eject("toB_eject_up", 1'b1, 10);
    wait_eject("toB_eject_down", 1'b0, 10);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("toB_hold", bus.fault, 0);
    end
    tick();
    check("toB_fault", bus.fault, 1);
    check("toB_rem", bus.remaining, 0);
    check("toB_busy", bus.busy, 0);
    do_reset();

    // reset in the middle of the first coin
    hop_mode = 1;
    pulse_start(2000);
    tick();
    check("mid_eject10", bus.eject10, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_outputs", {bus.eject10, bus.eject1, bus.eject050, bus.busy, bus.done, bus.fault}, 0);
    check("mid_rst_rem", bus.remaining, 0);
    rst = 1'b0;
    hop_mode = 0;
    tick();
    check("mid_idle", bus.busy, 0);
    plan(100, 1'b0, 1'b0);
    chk_en = 1'b1;
    pulse_start(100);
    check("mid_restart_busy", bus.busy, 1);
    wait_done("done_after_rst", 100);
    check("rem_after_rst", bus.remaining, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
